// File: rtl/mem_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_reader_pkg
// Description : Shared types and constants for the mem_reader read initiator:
//               controller state encoding and skid FIFO sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_reader_pkg;

    // Two entries cover the one-cycle RAM latency plus one word of backpressure
    localparam int c_FIFO_DEPTH = 2;
    localparam int c_FIFO_CNT_W = $clog2(c_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage : mem_reader_pkg
`default_nettype wire

// File: rtl/mem_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_reader_if
// Description : Control, RAM-port and output-stream signals of mem_reader.
//               master = the reader itself, slave = RAM/stream environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_reader_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 4
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic [ADDR_BITS:0]   length;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_data_in;
    logic [WORD_SIZE-1:0] mem_data_out;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        input  start, base_addr, length, mem_data_out, out_ready,
        output busy, done, mem_addr, mem_we, mem_data_in,
               out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, length, mem_data_out, out_ready,
        input  busy, done, mem_addr, mem_we, mem_data_in,
               out_data, out_valid, out_last
    );
endinterface : mem_reader_if
`default_nettype wire

// File: rtl/mem_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_reader_fifo
// Description : Two-entry skid FIFO with registered head. The head register
//               drives the output directly so data holds steady under stall.
//               Simultaneous push and pop is supported at count 1 or 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_reader_fifo
    import mem_reader_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    input  wire logic                    i_push,
    input  wire logic [WIDTH-1:0]        i_push_data,
    input  wire logic                    i_pop,
    output logic      [WIDTH-1:0]        o_head,
    output logic      [c_FIFO_CNT_W-1:0] o_count,
    output logic                         o_valid
);

    localparam logic [c_FIFO_CNT_W-1:0] c_CNT_ONE  = c_FIFO_CNT_W'(1);
    localparam logic [c_FIFO_CNT_W-1:0] c_CNT_FULL = c_FIFO_CNT_W'(c_FIFO_DEPTH);

    logic [WIDTH-1:0]        r_head;
    logic [WIDTH-1:0]        r_tail;
    logic [c_FIFO_CNT_W-1:0] r_count;
    logic                    w_do_pop;
    logic                    w_do_push;

    // Drop a pop on an empty FIFO and a push into a full FIFO that is not draining
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_CNT_FULL) || w_do_pop);

    // Entry storage and occupancy; head always holds the oldest word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_head <= i_push_data;
                    end else begin
                        r_tail <= i_push_data;
                    end
                    r_count <= r_count + c_CNT_ONE;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - c_CNT_ONE;
                end
                2'b11: begin
                    if (r_count == c_CNT_ONE) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;
    assign o_valid = (r_count != '0);

endmodule : mem_reader_fifo
`default_nettype wire

// File: rtl/mem_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_reader
// Description : Streams a contiguous, wrap-around range of RAM words onto a
//               valid/ready output. Absorbs the one-cycle RAM read latency and
//               downstream backpressure through a 2-entry skid FIFO.
//               Optional feature macro: MEM_READER_CLEAR_EN (read-and-clear:
//               every issued read also writes zero to the same address).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_BITS = 4
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    mem_reader_if.master  bus
);

    localparam logic [ADDR_BITS-1:0] c_ADDR_MAX = ADDR_BITS'(NUM_WORDS - 1);
    localparam logic [ADDR_BITS-1:0] c_ADDR_ONE = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   c_LEN_ONE  = (ADDR_BITS + 1)'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [ADDR_BITS:0]      r_issue_cnt;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_zero_len;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_pop;
    logic                    w_last_pop;
    logic [2:0]              w_occupancy;
    logic [ADDR_BITS-1:0]    w_addr_inc;

    logic [WORD_SIZE:0]      w_fifo_head;
    logic [c_FIFO_CNT_W-1:0] w_fifo_count;
    logic                    w_fifo_valid;

    // Request decode: only an idle reader honours start
    assign w_accept   = (r_state == IDLE) && bus.start && (bus.length != '0);
    assign w_zero_len = (r_state == IDLE) && bus.start && (bus.length == '0);

    // Words held or promised after this cycle's pop; capping it at the FIFO
    // depth guarantees every returning RAM word has a slot
    assign w_pop       = w_fifo_valid && bus.out_ready;
    assign w_last_pop  = w_pop && w_fifo_head[WORD_SIZE];
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_issue      = (r_state == RUN) && (r_issue_cnt != '0)
                        && (w_occupancy < 3'(c_FIFO_DEPTH));
    assign w_issue_last = w_issue && (r_issue_cnt == c_LEN_ONE);

    // Modulo-NUM_WORDS increment; depth need not be a power of two
    assign w_addr_inc = (r_addr == c_ADDR_MAX) ? '0 : (r_addr + c_ADDR_ONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: RUN until the final read issues, DRAIN until its word leaves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)     w_state_nxt = RUN;
            RUN:     if (w_issue_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_pop)   w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Address/counter, one-cycle in-flight tag and done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= '0;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= bus.base_addr;
                r_issue_cnt <= bus.length;
            end else if (w_issue) begin
                r_addr      <= w_addr_inc;
                r_issue_cnt <= r_issue_cnt - c_LEN_ONE;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            r_done          <= w_zero_len || w_last_pop;
        end
    end

    // Returning RAM word is captured together with its last-word tag
    mem_reader_fifo #(
        .WIDTH (WORD_SIZE + 1)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, bus.mem_data_out}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_valid     (w_fifo_valid)
    );

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.mem_addr  = r_addr;
    assign bus.out_data  = w_fifo_head[WORD_SIZE-1:0];
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_last  = w_fifo_valid && w_fifo_head[WORD_SIZE];

`ifdef MEM_READER_CLEAR_EN
    // Read-and-clear: the RAM returns the old word and stores zero in one cycle
    assign bus.mem_we      = w_issue;
    assign bus.mem_data_in = '0;
`else
    assign bus.mem_we      = 1'b0;
    assign bus.mem_data_in = '0;
`endif

endmodule : mem_reader
`default_nettype wire

// File: doc/mem_reader.md
Name: mem_reader

Overview:
Read initiator for the single-port synchronous RAM. On a start pulse it streams a contiguous, wrap-around range of RAM words onto a valid/ready output. It absorbs the RAM's one-cycle registered read latency and downstream backpressure without dropping or duplicating words. It sits between the sprite/register RAMs and the display/sprite pipeline.

Parameters:
WORD_SIZE, 16, RAM word width in bits
NUM_WORDS, 16, RAM depth; addresses wrap from NUM_WORDS-1 to 0 (need not be a power of 2)
ADDR_BITS, 4, RAM address width

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  ADDR_BITS  first word address, sampled with start
length  input  ADDR_BITS+1  number of words to read, 0..NUM_WORDS, sampled with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the transfer completes
mem_addr  output  ADDR_BITS  RAM address
mem_we  output  1  RAM write enable
mem_data_in  output  WORD_SIZE  RAM write data
mem_data_out  input  WORD_SIZE  RAM read data, valid one cycle after mem_addr
out_data  output  WORD_SIZE  streamed word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the word when out_valid && out_ready
out_last  output  1  high with the final word of the transfer

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE; FIFO emptied; in-flight read discarded.
  - busy, done, out_valid, out_last, mem_we = 0; mem_addr, mem_data_in, out_data = 0.
- FSM states IDLE, RUN, DRAIN.
  - IDLE: start with length>0 → latch base_addr; issue counter = length; go to RUN.
  - IDLE: start with length=0 → done pulses the next cycle; no data; busy stays 0.
  - RUN: issue reads until the issue counter reaches 0 → DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight. Done pulses in the cycle after the handshake of the out_last word, then → IDLE.
  - start while busy is ignored.
- Issue rule: a read is issued in a cycle when (fifo_count + inflight − pop_this_cycle) < 2.
  - mem_addr holds the current address register; on issue, address increments with wrap (NUM_WORDS-1 → 0).
  - inflight is set for exactly one cycle; the next cycle's mem_data_out is pushed into the FIFO.
- Skid FIFO: 2 entries, registered outputs.
  - out_valid = FIFO not empty; out_data/out_last come from the head entry.
  - out_data is stable while out_valid && !out_ready.
  - Simultaneous push and pop is legal at count 1 or 2.
- Latency, for start accepted in cycle T:
  - first read issued T+1; RAM data T+2; out_valid first high T+3.
- Throughput: with out_ready held high, one word per cycle and no bubbles after the first.
- out_last is attached to the word from the final issued read.
- Address arithmetic is modulo NUM_WORDS; length=NUM_WORDS reads every word exactly once.

Optional Feature:
MEM_READER_CLEAR_EN
- Defined (read-and-clear):
  - mem_we=1 and mem_data_in=0 in every issue cycle.
  - The RAM returns the old word (read-before-write) and clears it, with no throughput loss.
  - mem_we=0 in all other cycles.
- Undefined: mem_we and mem_data_in are tied to 0; the block is read-only.

Decomposition:
- Package mem_reader_pkg: state enum (IDLE, RUN, DRAIN) and FIFO depth constant (2).
- Sub-module mem_reader_fifo: 2-entry registered skid FIFO carrying {last, data}, with push/pop/count.

Test Plan:
- RAM[i]=i+0x100; start base=2, length=4, out_ready=1 → words 0x102..0x105 on consecutive cycles from T+3; out_last on 0x105; done one cycle after.
- base=14, length=5, NUM_WORDS=16 → addresses 14,15,0,1,2; data RAM[14],RAM[15],RAM[0],RAM[1],RAM[2].
- length=3, out_ready toggles 1,0,0,1,0,1 → each word emitted exactly once in order; out_data stable while stalled; at most 2 reads outstanding.
- length=0 → no out_valid; done pulses once the cycle after start. Second start while busy → ignored, no extra words.
- reset_n low mid-transfer (after 2 of 8 words) → all outputs 0 immediately; a new start then reads from the new base correctly.
- MEM_READER_CLEAR_EN defined, base=0, length=4 → streamed data equals the original contents; RAM[0..3] read back as 0 afterwards; mem_we high only in issue cycles.
